power_spec_accumulator: RTL

Parametrised power-spectrum accumulator for the signal-processing chain. It takes the per-bin power stream from the power-spectrum calculator and combines one or more consecutive FFT frames: either summing them (averaging) or keeping the per-bin maximum (peak hold). It then streams the final spectrum out with bin indices. It sits between the power-spectrum stage and the result readout, and the frame count, mode and output scaling are set at run time from the user register.

---
 rtl/power_spec_accumulator.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/power_spec_accumulator.sv
// Power-spectrum frame accumulator: sums or peak-holds per-bin power over a run of
// consecutive FFT frames in a read-modify-write RAM and streams the final frame out.
module power_spec_accumulator #(
   parameter int NBINS  = 1024,
   parameter int IDX_W  = $clog2(NBINS),
   parameter int DATA_W = 32,
   parameter int ACC_W  = 48,
   parameter int OUT_W  = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  acc_num_i,
   input  logic              mode_i,
   input  logic [5:0]        shift_i,
   input  logic              pwr_valid_i,
   input  logic              pwr_sof_i,
   input  logic [DATA_W-1:0] pwr_i,
   output logic              spec_valid_o,
   output logic [IDX_W-1:0]  spec_idx_o,
   output logic [OUT_W-1:0]  spec_o,
   output logic              spec_last_o,
   output logic              busy_o,
   output logic              err_o
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_SOF = 2'd1,
      S_ACCUM    = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NBINS - 1);
   localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
   localparam logic [OUT_W-1:0] OUT_MAX  = {OUT_W{1'b1}};

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    bin_cnt_q, bin_cnt_d;
   logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]    acc_num_q, acc_num_d;
   logic                mode_q, mode_d;
   logic [5:0]          shift_q, shift_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;

   logic                p1_valid_q, p1_valid_d;
   logic [IDX_W-1:0]    p1_bin_q, p1_bin_d;
   logic [DATA_W-1:0]   p1_pwr_q, p1_pwr_d;
   logic                p1_first_q, p1_first_d;
   logic                p1_out_q, p1_out_d;
   logic                p1_last_q, p1_last_d;

   logic                spec_valid_q, spec_valid_d;
   logic [IDX_W-1:0]    spec_idx_q, spec_idx_d;
   logic [OUT_W-1:0]    spec_q, spec_d;
   logic                spec_last_q, spec_last_d;

   logic [ACC_W-1:0]    mem [NBINS];
   logic [ACC_W-1:0]    rd_data_q;
   logic                last_frame_s;
   logic [ACC_W:0]      sum_s;
   logic [ACC_W-1:0]    pwr_ext_s;
   logic [ACC_W-1:0]    combined_s;
   logic [ACC_W-1:0]    shifted_s;
   logic [ACC_W+OUT_W-1:0] wide_s;

   assign last_frame_s = (frame_cnt_q == (acc_num_q - CNT_W'(1)));

   // Run control FSM; also decides whether this cycle's beat enters the RMW pipeline
   always_comb begin
      state_d     = state_q;
      bin_cnt_d   = bin_cnt_q;
      frame_cnt_d = frame_cnt_q;
      acc_num_d   = acc_num_q;
      mode_d      = mode_q;
      shift_d     = shift_q;
      err_d       = err_q;
      p1_valid_d  = 1'b0;
      p1_bin_d    = bin_cnt_q;
      p1_pwr_d    = pwr_i;
      p1_first_d  = (frame_cnt_q == CNT_W'(0));
      p1_out_d    = last_frame_s;
      p1_last_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               acc_num_d   = (acc_num_i == CNT_W'(0)) ? CNT_W'(1) : acc_num_i;
               mode_d      = mode_i;
               shift_d     = shift_i;
               err_d       = 1'b0;
               frame_cnt_d = CNT_W'(0);
               bin_cnt_d   = IDX_W'(0);
               state_d     = S_WAIT_SOF;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_SOF: begin
            if (pwr_valid_i && pwr_sof_i) begin
               p1_valid_d = 1'b1;
               p1_bin_d   = IDX_W'(0);
               bin_cnt_d  = IDX_W'(1);
               state_d    = S_ACCUM;
            end else begin
               state_d = S_WAIT_SOF;
            end
         end
         S_ACCUM: begin
            if (pwr_valid_i) begin
               p1_valid_d = 1'b1;
               // Early SOF: restart the whole run with this beat as bin 0 of frame 0
               if (pwr_sof_i && (bin_cnt_q != IDX_W'(0))) begin
                  err_d       = 1'b1;
                  frame_cnt_d = CNT_W'(0);
                  p1_bin_d    = IDX_W'(0);
                  p1_first_d  = 1'b1;
                  p1_out_d    = (acc_num_q == CNT_W'(1));
                  bin_cnt_d   = IDX_W'(1);
               end else if (bin_cnt_q == LAST_BIN) begin
                  p1_last_d = last_frame_s;
                  bin_cnt_d = IDX_W'(0);
                  if (last_frame_s) begin
                     state_d = S_IDLE;
                  end else begin
                     frame_cnt_d = frame_cnt_q + CNT_W'(1);
                     state_d     = S_WAIT_SOF;
                  end
               end else begin
                  bin_cnt_d = bin_cnt_q + IDX_W'(1);
               end
            end else begin
               state_d = S_ACCUM;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Combine stage: merge RAM word with the delayed beat, then scale and clip for output
   always_comb begin
      pwr_ext_s = ACC_W'(p1_pwr_q);
      sum_s     = {1'b0, rd_data_q} + {1'b0, pwr_ext_s};
      if (p1_first_q) begin
         combined_s = pwr_ext_s;
      end else if (mode_q) begin
         combined_s = (pwr_ext_s > rd_data_q) ? pwr_ext_s : rd_data_q;
      end else begin
         combined_s = sum_s[ACC_W] ? ACC_MAX : sum_s[ACC_W-1:0];
      end
      shifted_s = combined_s >> shift_q;
      wide_s    = (ACC_W+OUT_W)'(shifted_s);
      if (p1_valid_q && p1_out_q) begin
         spec_valid_d = 1'b1;
         spec_idx_d   = p1_bin_q;
         spec_d       = (|wide_s[ACC_W+OUT_W-1:OUT_W]) ? OUT_MAX : wide_s[OUT_W-1:0];
         spec_last_d  = p1_last_q;
      end else begin
         spec_valid_d = 1'b0;
         spec_idx_d   = IDX_W'(0);
         spec_d       = OUT_W'(0);
         spec_last_d  = 1'b0;
      end
   end

   // Accumulator RAM: read for the incoming beat, write back the combined value a cycle later
   always_ff @(posedge clk_i) begin
      if (p1_valid_q) begin
         mem[p1_bin_q] <= combined_s;
      end
      if (p1_valid_d) begin
         rd_data_q <= mem[p1_bin_d];
      end
   end

   // Control, pipeline and output registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         bin_cnt_q    <= IDX_W'(0);
         frame_cnt_q  <= CNT_W'(0);
         acc_num_q    <= CNT_W'(0);
         mode_q       <= 1'b0;
         shift_q      <= 6'd0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         p1_valid_q   <= 1'b0;
         p1_bin_q     <= IDX_W'(0);
         p1_pwr_q     <= DATA_W'(0);
         p1_first_q   <= 1'b0;
         p1_out_q     <= 1'b0;
         p1_last_q    <= 1'b0;
         spec_valid_q <= 1'b0;
         spec_idx_q   <= IDX_W'(0);
         spec_q       <= OUT_W'(0);
         spec_last_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bin_cnt_q    <= bin_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         acc_num_q    <= acc_num_d;
         mode_q       <= mode_d;
         shift_q      <= shift_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         p1_valid_q   <= p1_valid_d;
         p1_bin_q     <= p1_bin_d;
         p1_pwr_q     <= p1_pwr_d;
         p1_first_q   <= p1_first_d;
         p1_out_q     <= p1_out_d;
         p1_last_q    <= p1_last_d;
         spec_valid_q <= spec_valid_d;
         spec_idx_q   <= spec_idx_d;
         spec_q       <= spec_d;
         spec_last_q  <= spec_last_d;
      end
   end

   assign spec_valid_o = spec_valid_q;
   assign spec_idx_o   = spec_idx_q;
   assign spec_o       = spec_q;
   assign spec_last_o  = spec_last_q;
   assign busy_o       = busy_q;
   assign err_o        = err_q;

endmodule
